// File: rtl/ysyx_25060170_pkg.sv
// Shared definitions for the ysyx_25060170 load/store unit.
//   - lsu_state_e : FSM states (IDLE, REQ, WAIT, DONE)
//   - F3_*        : funct3 encodings for loads and stores
//   - f3_legal      : is a funct3 acceptable for a load or a store
//   - natural_align : forces address low bits to the access size
//   - is_misaligned : access low bits do not match the access size
package ysyx_25060170_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // funct3[1:0] carries the size: 00 byte, 01 half, 10 word.
  function automatic logic [1:0] natural_align(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return {lo[1], 1'b0};
      2'b10:   return 2'b00;
      default: return lo;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/ysyx_25060170_lsu_align.sv
// Combinational lane logic for the LSU.
//   funct3   in  access size/sign
//   addr_lo  in  byte offset within the word (already size-aligned)
//   st_data  in  raw store data (rs2)
//   ld_word  in  word returned by memory
//   st_mask  out byte strobes for a store
//   st_lanes out store data replicated across lanes
//   ld_data  out load value extracted and sign/zero extended
module ysyx_25060170_lsu_align
  import ysyx_25060170_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  st_mask,
  output logic [31:0] st_lanes,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = ld_word[{addr_lo, 3'b000} +: 8];
  assign ld_half = ld_word[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    st_mask  = 4'b1111;
    st_lanes = st_data;
    case (funct3[1:0])
      2'b00: begin
        st_mask  = 4'b0001 << addr_lo;
        st_lanes = {4{st_data[7:0]}};
      end
      2'b01: begin
        st_mask  = 4'b0011 << {addr_lo[1], 1'b0};
        st_lanes = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = '0;
    case (funct3)
      F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      F3_LW:   ld_data = ld_word;
      F3_LBU:  ld_data = {24'd0, ld_byte};
      F3_LHU:  ld_data = {16'd0, ld_half};
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_25060170_lsu.sv
// Load/store unit between EXU and WBU. One instruction in flight.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready               EXU handshake (in_ready = state is IDLE)
//   in_mem_rd/in_mem_wr/in_funct3   access kind and size
//   in_addr/in_wdata/in_wb_data     address, store data, pass-through value
//   mem_req_*                       memory request channel
//   mem_resp_valid/mem_resp_rdata   memory response / write acknowledge
//   out_valid/out_ready/out_rdata/out_err  WBU handshake and result
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; a valid producer keeps valid and its payload stable until then.
// Build option YSYX_25060170_LSU_MISALIGN_CHK_EN: when defined, misaligned
// half/word accesses are rejected with out_err; otherwise the address low
// bits are forced to natural alignment and the access proceeds.
module ysyx_25060170_lsu
  import ysyx_25060170_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mem_rd,
  input  logic              in_mem_wr,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [DATA_W-1:0] in_wb_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wen,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [3:0]        mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rdata,
  output logic              out_err
);

  lsu_state_e state, state_next;

  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic        is_mem;
  logic        f3_ok;
  logic        misaligned;
  logic        reject;
  logic [1:0]  lo_eff;
  logic [2:0]  al_f3;
  logic [1:0]  al_lo;
  logic [3:0]  al_mask;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;

  assign is_mem = in_mem_rd | in_mem_wr;
  assign f3_ok  = f3_legal(in_mem_wr, in_funct3);

`ifdef YSYX_25060170_LSU_MISALIGN_CHK_EN
  assign misaligned = is_misaligned(in_funct3, in_addr[1:0]);
  assign lo_eff     = in_addr[1:0];
`else
  assign misaligned = 1'b0;
  assign lo_eff     = natural_align(in_funct3, in_addr[1:0]);
`endif

  assign reject   = is_mem & (~f3_ok | misaligned);
  assign in_ready = (state == S_IDLE);

  // The lane logic sees the incoming instruction while IDLE (store encoding
  // is registered at accept) and the latched one afterwards (load extraction
  // is registered when the response arrives).
  assign al_f3 = (state == S_IDLE) ? in_funct3 : f3_q;
  assign al_lo = (state == S_IDLE) ? lo_eff    : lo_q;

  ysyx_25060170_lsu_align u_align (
    .funct3   (al_f3),
    .addr_lo  (al_lo),
    .st_data  (in_wdata),
    .ld_word  (mem_resp_rdata),
    .st_mask  (al_mask),
    .st_lanes (al_wdata),
    .ld_data  (al_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (in_valid) state_next = (is_mem && !reject) ? S_REQ : S_DONE;
      S_REQ:  if (mem_req_ready) state_next = S_WAIT;
      S_WAIT: if (mem_resp_valid) state_next = S_DONE;
      S_DONE: if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q          <= '0;
      lo_q          <= '0;
      mem_req_valid <= 1'b0;
      mem_req_wen   <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
      out_valid     <= 1'b0;
      out_rdata     <= '0;
      out_err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            f3_q <= in_funct3;
            lo_q <= lo_eff;
            if (is_mem && !reject) begin
              mem_req_valid <= 1'b1;
              mem_req_wen   <= in_mem_wr;
              mem_req_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
              mem_req_wdata <= in_mem_wr ? al_wdata : '0;
              mem_req_wmask <= in_mem_wr ? al_mask : 4'b0000;
              out_err       <= 1'b0;
            end else begin
              out_valid <= 1'b1;
              out_err   <= reject;
              out_rdata <= reject ? '0 : in_wb_data;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) mem_req_valid <= 1'b0;
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            out_valid <= 1'b1;
            out_err   <= 1'b0;
            out_rdata <= mem_req_wen ? '0 : al_rdata;
          end
        end
        S_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25060170_lsu.sv
`timescale 1ns/1ps
module tb_ysyx_25060170_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic        in_mem_rd = 1'b0, in_mem_wr = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_addr = '0, in_wdata = '0, in_wb_data = '0;
  logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_rdata = '0;
  logic        out_valid, out_ready = 1'b0, out_err;
  logic [31:0] out_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // results of the last run_op
  bit          saw_req, steady;
  logic [31:0] r_addr, r_wdata, o_rdata;
  logic [3:0]  r_mask;
  logic        r_wen, o_err;
  int          lat;

  always #5 clk = ~clk;

  ysyx_25060170_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr), .in_funct3(in_funct3),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_wb_data(in_wb_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rdata(out_rdata), .out_err(out_err)
  );

  // Reference model: what the access should produce, from size/offset arithmetic.
  function automatic void model(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] wbdata, input logic [31:0] rdata,
                                output bit acc, output logic err, output logic [31:0] res,
                                output logic [3:0] mask, output logic [31:0] lanes);
    int size, off;
    bit legal;
    logic [31:0] word, keep;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    acc = 0; err = 1'b0; res = '0; mask = '0; lanes = '0;
    if (!rd && !wr) begin
      res = wbdata;
      return;
    end
    legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    off = int'(addr[1:0]);
`ifdef YSYX_25060170_LSU_MISALIGN_CHK_EN
    if (off % size != 0) legal = 0;
`endif
    if (!legal) begin
      err = 1'b1;
      return;
    end
    off = off - (off % size);
    acc = 1;
    if (rd) begin
      word = rdata >> (8 * off);
      if (size < 4) begin
        keep = (32'd1 << (8 * size)) - 32'd1;
        word = word & keep;
        if (!f3[2] && word[8*size-1]) word = word | ~keep;
      end
      res = word;
    end else begin
      for (int i = 0; i < 4; i++) begin
        mask[i] = (i >= off) && (i < off + size);
        lanes[8*i +: 8] = wdata[8*(i % size) +: 8];
      end
    end
  endfunction

  // Drives one instruction from IDLE through the DONE handshake, acting as
  // memory. Records request fields, latency from accept and the result.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] wbdata, input logic [31:0] rdata,
                        input int req_stall, input int resp_delay, input int out_stall,
                        input bit noise);
    int cyc, stall_cnt, wait_cnt;
    bit hs, done;
    saw_req = 0; steady = 1; r_addr = '0; r_wdata = '0; r_mask = '0; r_wen = 1'b0;
    o_rdata = '0; o_err = 1'b0; lat = -1;
    cyc = 0; stall_cnt = 0; wait_cnt = 0; hs = 0; done = 0;
    in_valid = 1'b1; in_mem_rd = rd; in_mem_wr = wr; in_funct3 = f3;
    in_addr = addr; in_wdata = wdata; in_wb_data = wbdata;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_addr = $urandom; in_wdata = $urandom; in_wb_data = $urandom; in_funct3 = 3'($urandom);
    cyc = 1;
    while (!done && cyc < 60) begin
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = $urandom;
      if (in_ready !== 1'b0) steady = 0;
      if (out_valid === 1'b1) begin
        lat = cyc; o_rdata = out_rdata; o_err = out_err; done = 1;
      end else begin
        if (mem_req_valid === 1'b1) begin
          if (!saw_req) begin
            saw_req = 1; r_addr = mem_req_addr; r_wdata = mem_req_wdata;
            r_mask = mem_req_wmask; r_wen = mem_req_wen;
          end else if ({mem_req_addr, mem_req_wdata, mem_req_wmask, mem_req_wen} !==
                       {r_addr, r_wdata, r_mask, r_wen}) begin
            steady = 0;
          end
          if (stall_cnt < req_stall) begin
            stall_cnt++;
            if (noise) mem_resp_valid = 1'($urandom_range(0, 1));
          end else begin
            mem_req_ready = 1'b1;
            hs = 1;
          end
        end else if (hs) begin
          if (wait_cnt < resp_delay) wait_cnt++;
          else begin
            mem_resp_valid = 1'b1;
            mem_resp_rdata = rdata;
          end
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout: out_valid not seen within %0d cycles", cyc);
    end else begin
      repeat (out_stall) begin
        out_ready = 1'b0;
        @(posedge clk); #1;
        if (out_valid !== 1'b1 || out_rdata !== o_rdata || out_err !== o_err || in_ready !== 1'b0)
          steady = 0;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({in_ready, mem_req_valid, mem_req_wen, out_valid, out_err} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 10000",
               {in_ready, mem_req_valid, mem_req_wen, out_valid, out_err});
    end
    checks++;
    if ({mem_req_addr, mem_req_wdata, mem_req_wmask, out_rdata} !== 100'd0) begin
      errors++;
      $display("FAIL reset_data: addr %h wdata %h wmask %b rdata %h want all 0",
               mem_req_addr, mem_req_wdata, mem_req_wmask, out_rdata);
    end
  endtask

  task automatic test_lbu();
    run_op(1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'h0, 32'hA1B2_C3D4, 0, 0, 0, 1'b0);
    checks++;
    if (r_addr !== 32'h8000_0000 || r_wen !== 1'b0 || !saw_req) begin
      errors++; $display("FAIL lbu_req: addr %h wen %b want 80000000 0", r_addr, r_wen);
    end
    checks++;
    if (o_rdata !== 32'h0000_00A1 || o_err !== 1'b0) begin
      errors++; $display("FAIL lbu_data: got %h err %b want 000000a1 0", o_rdata, o_err);
    end
  endtask

  task automatic test_lh();
    run_op(1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'h0, 32'h8001_1234, 0, 0, 0, 1'b0);
    checks++;
    if (o_rdata !== 32'hFFFF_8001) begin
      errors++; $display("FAIL lh_data: got %h want ffff8001", o_rdata);
    end
    checks++;
    if (lat !== 3) begin
      errors++; $display("FAIL lh_latency: got %0d want 3", lat);
    end
  endtask

  task automatic test_sb_stall();
    run_op(1'b0, 1'b1, 3'b000, 32'h0000_0010, 32'h0000_0055, 32'h0, 32'h0, 3, 0, 0, 1'b1);
    checks++;
    if (r_mask !== 4'b0001 || r_wdata !== 32'h5555_5555 || r_wen !== 1'b1 || r_addr !== 32'h10) begin
      errors++;
      $display("FAIL sb_req: mask %b wdata %h wen %b addr %h want 0001 55555555 1 00000010",
               r_mask, r_wdata, r_wen, r_addr);
    end
    checks++;
    if (!steady || lat !== 6 || o_rdata !== 32'h0 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL sb_stall: steady %0d lat %0d rdata %h err %b want 1 6 0 0",
               steady, lat, o_rdata, o_err);
    end
  endtask

  task automatic test_misaligned_lw();
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 1'b0);
    checks++;
`ifdef YSYX_25060170_LSU_MISALIGN_CHK_EN
    if (saw_req || o_err !== 1'b1 || o_rdata !== 32'h0 || lat !== 1) begin
      errors++;
      $display("FAIL misaligned_lw: req %0d err %b rdata %h lat %0d want 0 1 0 1",
               saw_req, o_err, o_rdata, lat);
    end
`else
    if (!saw_req || r_addr !== 32'h4 || o_err !== 1'b0 || o_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL misaligned_lw: req %0d addr %h err %b rdata %h want 1 4 0 deadbeef",
               saw_req, r_addr, o_err, o_rdata);
    end
`endif
  endtask

  task automatic test_illegal();
    run_op(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 32'h1, 0, 0, 0, 1'b0);
    checks++;
    if (saw_req || o_err !== 1'b1 || o_rdata !== 32'h0 || lat !== 1) begin
      errors++;
      $display("FAIL illegal_load: req %0d err %b rdata %h lat %0d want 0 1 0 1",
               saw_req, o_err, o_rdata, lat);
    end
    run_op(1'b0, 1'b1, 3'b100, 32'h100, 32'hFF, 32'h0, 32'h1, 0, 0, 0, 1'b0);
    checks++;
    if (saw_req || o_err !== 1'b1 || o_rdata !== 32'h0 || lat !== 1) begin
      errors++;
      $display("FAIL illegal_store: req %0d err %b rdata %h lat %0d want 0 1 0 1",
               saw_req, o_err, o_rdata, lat);
    end
  endtask

  task automatic test_passthrough();
    run_op(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0000_1234, 32'h0, 0, 0, 2, 1'b0);
    checks++;
    if (o_rdata !== 32'h1234 || o_err !== 1'b0 || lat !== 1 || saw_req) begin
      errors++;
      $display("FAIL passthru: rdata %h err %b lat %0d req %0d want 1234 0 1 0",
               o_rdata, o_err, lat, saw_req);
    end
    checks++;
    if (!steady || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL passthru_hold: steady %0d out_valid %b in_ready %b want 1 0 1",
               steady, out_valid, in_ready);
    end
  endtask

  task automatic test_reset_in_wait();
    bit quiet;
    in_valid = 1'b1; in_mem_rd = 1'b1; in_mem_wr = 1'b0; in_funct3 = 3'b010; in_addr = 32'h40;
    @(posedge clk); #1;                      // REQ
    in_valid = 1'b0; in_mem_rd = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;                      // WAIT
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || mem_req_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_wait: out_valid %b req_valid %b in_ready %b want 0 0 1",
               out_valid, mem_req_valid, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    quiet = 1;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFE_F00D;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || mem_req_valid !== 1'b0 || in_ready !== 1'b1) quiet = 0;
    end
    mem_resp_valid = 1'b0;
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL late_resp: out_valid %b in_ready %b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic rd, wr, err_e;
    logic [2:0] f3;
    logic [31:0] addr, wdata, wbdata, rdata, res_e, lanes_e, want;
    logic [3:0] mask_e;
    bit acc;
    int rs, rdly, exp_lat;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0: begin rd = 1'b1; wr = 1'b0; end
        1: begin rd = 1'b0; wr = 1'b1; end
        default: begin rd = 1'b0; wr = 1'b0; end
      endcase
      f3 = 3'($urandom_range(0, 7));
      addr = $urandom; wdata = $urandom; wbdata = $urandom; rdata = $urandom;
      rs = $urandom_range(0, 2); rdly = $urandom_range(0, 2);
      model(rd, wr, f3, addr, wdata, wbdata, rdata, acc, err_e, res_e, mask_e, lanes_e);
      exp_q.push_back(res_e);
      exp_lat = acc ? 3 + rs + rdly : 1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready[%0d]: in_ready %b want 1", n, in_ready);
      end
      run_op(rd, wr, f3, addr, wdata, wbdata, rdata, rs, rdly, $urandom_range(0, 2), 1'b1);
      want = exp_q.pop_front();
      checks++;
      if (o_rdata !== want || o_err !== err_e) begin
        errors++;
        $display("FAIL b2b_result[%0d]: rd %b wr %b f3 %b addr %h got %h err %b want %h err %b",
                 n, rd, wr, f3, addr, o_rdata, o_err, want, err_e);
      end
      checks++;
      if (saw_req !== acc || lat !== exp_lat || !steady) begin
        errors++;
        $display("FAIL b2b_timing[%0d]: req %0d lat %0d steady %0d want req %0d lat %0d steady 1",
                 n, saw_req, lat, steady, acc, exp_lat);
      end
      if (acc) begin
        checks++;
        if (r_addr !== (addr & ~32'h3) || r_wen !== wr ||
            (wr && (r_mask !== mask_e || r_wdata !== lanes_e))) begin
          errors++;
          $display("FAIL b2b_req[%0d]: addr %h wen %b mask %b wdata %h want %h %b %b %h",
                   n, r_addr, r_wen, r_mask, r_wdata, addr & ~32'h3, wr, mask_e, lanes_e);
        end
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_lbu();
    test_lh();
    test_sb_stall();
    test_misaligned_lw();
    test_illegal();
    test_passthrough();
    test_reset_in_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
